// File: rtl/sap_pkg.sv
// Shared SAP machine definitions: memory geometry and the boot loader state set.
// The memory, PC and loader all size themselves from these constants.
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;
    localparam int SAP_DEPTH  = 1 << SAP_ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: holds the CPU while a length-prefixed image streams into RAM,
// then releases it only if the trailing checksum makes the byte sum zero.
module prog_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W,
    parameter int DEPTH  = SAP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              hs;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  len_eff;
    logic [DATA_W-1:0] chk_sum;

    assign in_ready = (state_q == LOAD) || (state_q == CHECK);
    assign hs       = in_valid && in_ready;
    assign cnt_inc  = cnt_q + ONE_C;
    assign chk_sum  = sum_q + in_data;

    // A zero or oversized length means "fill the whole RAM".
    assign len_eff  = ((len == '0) || (len > DEPTH_C)) ? DEPTH_C : len;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_d = LOAD;
                    n_d     = len_eff;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    cnt_d   = cnt_inc;
                    sum_d   = chk_sum;
                    if (cnt_inc == n_q) state_d = CHECK;
                end
            end
            CHECK: begin
                // Checksum byte is consumed here and never reaches the RAM.
                if (hs) state_d = (chk_sum == '0) ? RUN : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == LOAD) || (state_q == CHECK);
    assign done      = (state_q == RUN);
    assign err       = (state_q == ERROR);
    assign cpu_hold  = (state_q != RUN);

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized checks of prog_loader against an image-level reference model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [4:0] len;
    logic [7:0] in_data;
    logic       in_ready, mem_we, cpu_hold, busy, done, err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 taking image, 2 awaiting checksum, 3 running, 4 failed.
    int         ph = 0;
    int         need = 0;
    logic [7:0] img[$];
    logic       m_we = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] bytes_b [16];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic [4:0] l, input logic v,
                        input logic [7:0] d, input logic r);
        logic hs;
        int   tot;
        hs = r && v && (ph == 1 || ph == 2);
        if (!r) begin
            ph = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; img.delete();
        end else begin
            m_we = 1'b0;
            if (ph == 1) begin
                if (hs) begin
                    m_we = 1'b1; m_addr = 4'(img.size()); m_wdata = d;
                    img.push_back(d);
                    if (img.size() == need) ph = 2;
                end
            end else if (ph == 2) begin
                if (hs) begin
                    tot = int'(d);
                    foreach (img[i]) tot += int'(img[i]);
                    ph = (tot % 256 == 0) ? 3 : 4;
                end
            end else if (s) begin
                ph = 1;
                need = (l == 0 || l > 16) ? 16 : int'(l);
                img.delete();
            end
        end
        start = s; len = l; in_valid = v; in_data = d; rst = r;
        @(posedge clk); #1;
        chk("in_ready", 8'(in_ready), 8'(ph == 1 || ph == 2));
        chk("busy", 8'(busy), 8'(ph == 1 || ph == 2));
        chk("done", 8'(done), 8'(ph == 3));
        chk("err", 8'(err), 8'(ph == 4));
        chk("cpu_hold", 8'(cpu_hold), 8'(ph != 3));
        chk("mem_we", 8'(mem_we), 8'(m_we));
        chk("mem_addr", 8'(mem_addr), 8'(m_addr));
        chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    function automatic logic [7:0] good_csum(input int nb);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < nb; i++) s = s + bytes_b[i];
        return 8'h00 - s;
    endfunction

    task automatic gap_cycles();
        // Idle stream cycles; stray start pulses here must be ignored mid-load.
        while ($urandom_range(0, 2) == 0)
            step(1'($urandom_range(0, 1)), 5'($urandom), 1'b0, 8'($urandom), 1'b1);
    endtask

    task automatic send_image(input int ln, input int nb, input logic [7:0] c, input bit gapped);
        step(1'b1, 5'(ln), 1'b0, 8'($urandom), 1'b1);
        for (int i = 0; i < nb; i++) begin
            if (gapped) gap_cycles();
            step(1'b0, 5'd0, 1'b1, bytes_b[i], 1'b1);
        end
        if (gapped) gap_cycles();
        step(1'b0, 5'd0, 1'b1, c, 1'b1);
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 16; i++) bytes_b[i] = 8'($urandom);
    endtask

    initial begin
        int ln, nb;
        logic [7:0] c;

        // Reset state, then idle stream traffic must not write.
        step(1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 5'd0, 1'b1, 8'h55, 1'b1);

        // Good load of three bytes.
        bytes_b[0] = 8'h10; bytes_b[1] = 8'h20; bytes_b[2] = 8'h30;
        send_image(3, 3, 8'hA0, 1'b0);
        chk("good_done", 8'(done), 8'h01);
        step(1'b0, 5'd0, 1'b1, 8'h77, 1'b1);

        // Bad checksum, then recovery with a correct image.
        send_image(3, 3, 8'hA1, 1'b0);
        chk("bad_err", 8'(err), 8'h01);
        step(1'b0, 5'd0, 1'b0, 8'h00, 1'b1);
        rand_bytes();
        send_image(5, 5, good_csum(5), 1'b0);
        chk("recover_done", 8'(done), 8'h01);

        // len=0 fills the whole RAM; the 17th byte is the checksum.
        rand_bytes();
        send_image(0, 16, good_csum(16), 1'b0);

        // Stalled stream: valid pattern 1,0,0,1,1.
        rand_bytes();
        step(1'b1, 5'd3, 1'b0, 8'h00, 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[0], 1'b1);
        step(1'b0, 5'd0, 1'b0, 8'hEE, 1'b1);
        step(1'b0, 5'd0, 1'b0, 8'hDD, 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[1], 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[2], 1'b1);
        step(1'b0, 5'd0, 1'b1, good_csum(3), 1'b1);
        step(1'b0, 5'd0, 1'b0, 8'h00, 1'b1);

        // Reset after 2 of 5 bytes, then stream traffic while idle.
        rand_bytes();
        step(1'b1, 5'd5, 1'b0, 8'h00, 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[0], 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[1], 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[2], 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b1, bytes_b[3 + i], 1'b1);

        // Start pulse after the first of four bytes is ignored.
        rand_bytes();
        step(1'b1, 5'd4, 1'b0, 8'h00, 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[0], 1'b1);
        step(1'b1, 5'd2, 1'b1, bytes_b[1], 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[2], 1'b1);
        step(1'b0, 5'd0, 1'b1, bytes_b[3], 1'b1);
        step(1'b0, 5'd0, 1'b1, good_csum(4), 1'b1);
        chk("ignored_start_done", 8'(done), 8'h01);

        // Oversized lengths clamp to a full image.
        rand_bytes();
        send_image(20, 16, good_csum(16), 1'b1);
        rand_bytes();
        send_image(31, 16, good_csum(16), 1'b0);

        // Randomized loads with gaps and mixed checksum outcomes.
        for (int k = 0; k < 25; k++) begin
            rand_bytes();
            ln = $urandom_range(0, 31);
            nb = (ln == 0 || ln > 16) ? 16 : ln;
            c  = good_csum(nb);
            if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_image(ln, nb, c, 1'b1);
            if ($urandom_range(0, 1) == 1)
                step(1'b0, 5'd0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the SAP machine. Holds the CPU (clock-halt and controller in reset) while it accepts a length-prefixed program image over a valid/ready byte stream. It writes the image into the 16-byte RAM through the memory write port and verifies a trailing 8-bit checksum. Only after a good checksum does it release the CPU to run from address 0.

## Interface
Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, byte width; matches the 8-bit bus.
- DEPTH, 16, RAM depth; equals 2**ADDR_W.

Ports:
- clk  in  1  system clock. One clock domain; this is the undivided clock, not the halt-gated CPU clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a load.
- len  in  ADDR_W+1  number of program bytes, sampled on start. 0 means DEPTH. Values above DEPTH are clamped to DEPTH.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  RAM write strobe, one cycle per byte.
- mem_addr  out  ADDR_W  RAM write address.
- mem_wdata  out  DATA_W  RAM write data.
- cpu_hold  out  1  when high, the CPU is held: it drives the halt input and the controller/PC reset.
- busy  out  1  high in LOAD or CHECK.
- done  out  1  image loaded and verified; CPU running.
- err  out  1  checksum mismatch on the last load.

## Operation
- The loader is an FSM with states IDLE, LOAD, CHECK, RUN and ERROR.
- A handshake occurs when in_valid and in_ready are both high on a rising clk edge.

Transitions:
- IDLE: start latches the effective length N (1..16), clears the count and the running sum, then goes to LOAD.
- LOAD: each handshake writes in_data to address count. It then does count += 1 and sum += in_data (mod 256). The handshake that makes count == N goes to CHECK.
- CHECK: the next handshake accepts the checksum byte C. This byte is never written to RAM.
  - If (sum + C) mod 256 == 0, go to RUN.
  - Otherwise go to ERROR.
- RUN: start goes to LOAD with a new N. The CPU is re-held from that cycle on.
- ERROR: start goes to LOAD, the same as from RUN.

Boundaries and conflicts:
- start is ignored in LOAD and CHECK.
- start in IDLE, RUN or ERROR always restarts from address 0.
- The address never exceeds N-1. With N=16, the last write goes to address 15 and the count does not wrap into a 17th write.
- in_valid gaps stall the loader indefinitely; there is no timeout.

## Timing
Reset values (rst low at an edge):
- State goes to IDLE.
- cpu_hold=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- busy=0, done=0, err=0; count and sum are 0.
- This applies in any state, including mid-LOAD. Bytes already written stay in RAM.

Outputs:
- in_ready is a Moore output: high exactly in LOAD and CHECK.
- After the final data handshake, in_ready stays high (CHECK).
- After the checksum handshake, in_ready is 0 from the next cycle.
- busy, done, err and cpu_hold are registered Moore outputs of the state.
  - done=1 only in RUN.
  - err=1 only in ERROR.
  - cpu_hold=0 only in RUN.

Write path:
- The write is registered. The cycle after a LOAD handshake, mem_we=1 with mem_addr and mem_wdata holding the accepted address and byte.
- Back-to-back handshakes produce back-to-back write strobes.

Latency:
- From the checksum handshake to cpu_hold falling is 1 cycle.
- From start to in_ready rising is 1 cycle.

## Structure
- The shared package sap_pkg holds:
  - the loader_state_t enum (IDLE, LOAD, CHECK, RUN, ERROR);
  - the SAP_ADDR_W and SAP_DEPTH constants, which are reused by the memory and PC.
- No sub-module. The FSM, counter, checksum accumulator and write register live in one module.
- The top level ORs cpu_hold into the halt term and into the PC/controller reset.

## Test plan
- Good load, len=3: bytes 0x10, 0x20, 0x30, then C=0xA0.
  - Writes go to addr 0, 1, 2 with those values.
  - cpu_hold falls 1 cycle after the C handshake; done=1, err=0.
- Bad checksum, same image with C=0xA1:
  - State goes to ERROR; err=1 and cpu_hold stays 1.
  - A following start with a correct image reaches RUN and clears err.
- len=0: 16 bytes are written to addresses 0..15. The 17th handshake is treated as the checksum, with no write.
- Stalled stream: in_valid toggles 1,0,0,1,1.
  - mem_we pulses only in the cycles after handshakes.
  - The address increments only on accepted bytes.
- Reset mid-load: rst goes low after 2 of 5 bytes.
  - The next cycle shows IDLE, in_ready=0, mem_we=0, cpu_hold=1.
  - Further in_valid produces no writes.
- start during LOAD: a pulse after byte 1 of 4 is ignored. Addresses continue 1, 2, 3 and the load completes normally.
